// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the AXI4-Lite load/store unit.
//   lsu_state_t   - FSM states of lsu_axil
//   SIZE_*        - encodings of the mem_size request field
//   AXI_RESP_OKAY - the only response code that is not a fault
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      DONE
   } lsu_state_t;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   size, offset, is_signed, rsb, rdata - latched request fields and read data
//   chk_size, chk_offset                - incoming request, for the alignment check
//   wstrb, wdata                        - store lane strobes and replicated data
//   load_data                           - extracted and extended load result
//   misaligned                          - incoming request crosses its natural alignment
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_signed,
   input  logic [31:0] rsb,
   input  logic [31:0] rdata,
   input  logic [1:0]  chk_size,
   input  logic [1:0]  chk_offset,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [31:0] shifted;

   always_comb begin
      // Bring the addressed byte lane down to bit 0.
      shifted   = rdata >> {offset, 3'b000};
      wstrb     = 4'hF;
      wdata     = rsb;
      load_data = shifted;
      case (size)
         SIZE_B: begin
            wstrb     = 4'b0001 << offset;
            wdata     = {4{rsb[7:0]}};
            load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
         end
         SIZE_H: begin
            wstrb     = 4'b0011 << offset;
            wdata     = {2{rsb[15:0]}};
            load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
         end
         default: begin
         end
      endcase
      misaligned = ((chk_size == SIZE_H) && chk_offset[0])
                || ((chk_size == SIZE_W) && (chk_offset != 2'b00));
   end

endmodule

// File: rtl/lsu_axil.sv
// lsu_axil: multi-cycle load/store unit with an AXI4-Lite master port.
//   clk, rst                                - clock, synchronous active-high reset
//   lsu_receive_valid/ready, ren, wen,
//   mem_size, memory_read_signed,
//   exu_result, rsb                         - request from execute
//   lsu_send_valid/ready, memory_read_wd,
//   lsu_fault                               - result to writeback
//   ar*, r*, aw*, w*, b*                    - AXI4-Lite master channels
// All handshake outputs are registers, so no valid ever depends on a ready.
module lsu_axil
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_receive_valid,
   output logic              lsu_receive_ready,
   input  logic              ren,
   input  logic              wen,
   input  logic [1:0]        mem_size,
   input  logic              memory_read_signed,
   input  logic [DATA_W-1:0] exu_result,
   input  logic [DATA_W-1:0] rsb,
   output logic              lsu_send_valid,
   input  logic              lsu_send_ready,
   output logic [DATA_W-1:0] memory_read_wd,
   output logic              lsu_fault,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
);

   lsu_state_t        state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [1:0]        size_reg;
   logic              signed_reg;
   logic [DATA_W-1:0] rsb_reg;
   logic [DATA_W-1:0] result_reg;
   logic              fault_reg;
   logic              receive_ready_reg;
   logic              send_valid_reg;
   logic              arvalid_reg;
   logic              rready_reg;
   logic              awvalid_reg;
   logic              wvalid_reg;
   logic              bready_reg;
   logic              aw_done_reg;
   logic              w_done_reg;

   logic              aw_hs;
   logic              w_hs;
   logic [31:0]       load_data;
   logic              misaligned;

   lsu_align u_align (
      .size       (size_reg),
      .offset     (addr_reg[1:0]),
      .is_signed  (signed_reg),
      .rsb        (rsb_reg),
      .rdata      (rdata),
      .chk_size   (mem_size),
      .chk_offset (exu_result[1:0]),
      .wstrb      (wstrb),
      .wdata      (wdata),
      .load_data  (load_data),
      .misaligned (misaligned)
   );

   assign aw_hs = awvalid_reg && awready;
   assign w_hs  = wvalid_reg && wready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         addr_reg          <= '0;
         size_reg          <= SIZE_B;
         signed_reg        <= 1'b0;
         rsb_reg           <= '0;
         result_reg        <= '0;
         fault_reg         <= 1'b0;
         receive_ready_reg <= 1'b1;
         send_valid_reg    <= 1'b0;
         arvalid_reg       <= 1'b0;
         rready_reg        <= 1'b0;
         awvalid_reg       <= 1'b0;
         wvalid_reg        <= 1'b0;
         bready_reg        <= 1'b0;
         aw_done_reg       <= 1'b0;
         w_done_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (lsu_receive_valid) begin
                  addr_reg          <= exu_result[ADDR_W-1:0];
                  size_reg          <= mem_size;
                  signed_reg        <= memory_read_signed;
                  rsb_reg           <= rsb;
                  receive_ready_reg <= 1'b0;
                  fault_reg         <= 1'b0;
                  result_reg        <= '0;
                  // Misalignment only matters for real memory accesses.
                  if ((ren || wen) && misaligned) begin
                     fault_reg      <= 1'b1;
                     send_valid_reg <= 1'b1;
                     state_reg      <= DONE;
                  end else if (ren) begin
                     arvalid_reg <= 1'b1;
                     state_reg   <= RD_ADDR;
                  end else if (wen) begin
                     awvalid_reg <= 1'b1;
                     wvalid_reg  <= 1'b1;
                     aw_done_reg <= 1'b0;
                     w_done_reg  <= 1'b0;
                     state_reg   <= WR_REQ;
                  end else begin
                     result_reg     <= exu_result;
                     send_valid_reg <= 1'b1;
                     state_reg      <= DONE;
                  end
               end
            end
            RD_ADDR: begin
               if (arready) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
                  state_reg   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rvalid) begin
                  rready_reg     <= 1'b0;
                  result_reg     <= load_data;
                  fault_reg      <= (rresp != AXI_RESP_OKAY);
                  send_valid_reg <= 1'b1;
                  state_reg      <= DONE;
               end
            end
            WR_REQ: begin
               // AW and W complete independently, possibly in the same cycle.
               if (aw_hs) begin
                  awvalid_reg <= 1'b0;
                  aw_done_reg <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_reg <= 1'b0;
                  w_done_reg <= 1'b1;
               end
               if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                  bready_reg <= 1'b1;
                  state_reg  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (bvalid) begin
                  bready_reg     <= 1'b0;
                  fault_reg      <= (bresp != AXI_RESP_OKAY);
                  result_reg     <= '0;
                  send_valid_reg <= 1'b1;
                  state_reg      <= DONE;
               end
            end
            DONE: begin
               if (lsu_send_ready) begin
                  send_valid_reg    <= 1'b0;
                  receive_ready_reg <= 1'b1;
                  state_reg         <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign lsu_receive_ready = receive_ready_reg;
   assign lsu_send_valid    = send_valid_reg;
   assign memory_read_wd    = result_reg;
   assign lsu_fault         = fault_reg;
   assign araddr            = {addr_reg[ADDR_W-1:2], 2'b00};
   assign awaddr            = {addr_reg[ADDR_W-1:2], 2'b00};
   assign arvalid           = arvalid_reg;
   assign rready            = rready_reg;
   assign awvalid           = awvalid_reg;
   assign wvalid            = wvalid_reg;
   assign bready            = bready_reg;

endmodule

// File: doc/lsu_axil.md
# lsu_axil

Multi-cycle load/store unit that replaces the single-cycle DPI memory path with an AXI4-Lite master. Sits between the execute stage (consumes its result as address, plus the decoded memory controls) and the writeback unit (produces the load data or pass-through result with a valid/ready handshake). Handles byte, halfword and word accesses, byte-lane alignment, sign extension, misalignment detection and bus error reporting.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Only 32 is supported.

- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `lsu_receive_valid` in 1: upstream request valid.
- `lsu_receive_ready` out 1: unit can accept a request.
- `ren` in 1: load request.
- `wen` in 1: store request. `ren` and `wen` are never both 1.
- `mem_size` in 2: access size. 00 = byte, 01 = half, 10 = word.
- `memory_read_signed` in 1: sign-extend load data.
- `exu_result` in 32: effective address, or pass-through result.
- `rsb` in 32: store data.
- `lsu_send_valid` out 1: result valid to writeback.
- `lsu_send_ready` in 1: writeback accepts the result.
- `memory_read_wd` out 32: load data, or the latched `exu_result` for non-memory requests.
- `lsu_fault` out 1: the delivered result is a misaligned access or bus error. Qualified by `lsu_send_valid`.
- AXI4-Lite master channels:
  - `araddr`/`arvalid`/`arready`
  - `rdata`/`rresp`/`rvalid`/`rready`
  - `awaddr`/`awvalid`/`awready`
  - `wdata`/`wstrb`/`wvalid`/`wready`
  - `bresp`/`bvalid`/`bready`
  - Widths are 32, 1, 1, 32, 2, 1, 1, 32, 1, 1, 32, 4, 1, 1, 2, 1, 1.

## Operation
- **Accept.** A request is accepted on a cycle with `lsu_receive_valid && lsu_receive_ready`.
  - `lsu_receive_ready` is 1 only in IDLE.
  - At acceptance, latch `ren`, `wen`, `mem_size`, `memory_read_signed`, `exu_result` and `rsb`.
- **FSM states:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- **IDLE, on accept:**
  - Misaligned request → DONE with fault=1. No bus traffic. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise `ren` → RD_ADDR.
  - Otherwise `wen` → WR_REQ.
  - Otherwise → DONE with result = `exu_result`.
- **RD_ADDR:** `arvalid`=1, `araddr`={addr[31:2],2'b00}. On `arready` → RD_DATA.
- **RD_DATA:** `rready`=1. On `rvalid`:
  - Latch the extracted data and set fault = (`rresp`≠0).
  - Go to DONE.
- **WR_REQ:**
  - `awvalid` and `wvalid` are driven independently.
  - Each drops after its own handshake; per-channel done flags are tracked.
  - Both handshakes may occur in the same cycle.
  - When both are done → WR_RESP.
- **WR_RESP:** `bready`=1. On `bvalid`: set fault = (`bresp`≠0), result=0, go to DONE.
- **DONE:**
  - `lsu_send_valid`=1, with `memory_read_wd` and `lsu_fault` held stable.
  - On `lsu_send_ready` → IDLE.
- **Store lanes** (o = addr[1:0]):
  - Byte: `wstrb` = 4'b0001<<o, `wdata` = {4{rsb[7:0]}}.
  - Half: `wstrb` = 4'b0011<<o, `wdata` = {2{rsb[15:0]}}.
  - Word: `wstrb` = 4'hF, `wdata` = rsb.
- **Load extraction:**
  - s = `rdata` >> (8·o).
  - Byte: s[7:0], zero- or sign-extended from bit 7 per `memory_read_signed`.
  - Half: s[15:0], zero- or sign-extended from bit 15 per `memory_read_signed`.
  - Word: s.
- **Bus signal stability:** AXI valid signals never depend combinationally on the corresponding ready. Address and data are held stable while valid is asserted.

## Timing
- **Reset** (sync, takes priority over all else):
  - State = IDLE.
  - All AXI `*valid`/`*ready` outputs = 0.
  - `lsu_send_valid`=0, `lsu_fault`=0, `memory_read_wd`=0.
  - `lsu_receive_ready`=1 from the first cycle after reset.
- **Reset mid-transaction:** the outstanding bus transaction is abandoned and no result is delivered. The slave is reset alongside.
- **Latency with zero-wait slave** (ready or response in the same cycle the channel is valid):
  - Load: accept at cycle 0; `arvalid` at cycle 1; `rready` at cycle 2; `lsu_send_valid` at cycle 3.
  - Store: accept at cycle 0; `awvalid`/`wvalid` at cycle 1; `bready` at cycle 2; `lsu_send_valid` at cycle 3.
  - Non-memory or misaligned: `lsu_send_valid` at cycle 1.
- **Wait states:** each wait cycle on any channel adds exactly one cycle.
- **Back-to-back requests:** the next request can be accepted in the cycle after the DONE handshake (IDLE). Throughput is one request per ≥2 cycles.
- **Backpressure:** `lsu_send_ready`=0 holds DONE indefinitely, with all outputs stable.

## Structure
- Package `lsu_pkg`:
  - `lsu_state_t` enum for the six states.
  - Size constants `SIZE_B`=2'b00, `SIZE_H`=2'b01, `SIZE_W`=2'b10.
  - `AXI_RESP_OKAY`=2'b00.
- Sub-module `lsu_align`, purely combinational:
  - Store-lane generation (`wstrb`/`wdata`) from size, offset and `rsb`.
  - Load extraction and extension from size, offset, signed flag and `rdata`.
  - Also provides the misalignment flag.
- Top `lsu_axil` holds the FSM, the request latches, the AW/W done flags and the result register.

## Test plan
- Signed byte load: addr 0x80000003, `rdata`=0x80FF1234, `memory_read_signed`=1, zero-wait → `araddr`=0x80000000, `memory_read_wd`=0xFFFFFF80, `lsu_fault`=0, `lsu_send_valid` 3 cycles after accept.
- Unsigned half load: addr 0x80000002, `rdata`=0xBEEF0000 → 0x0000BEEF.
- Half store: addr 0x80000002, `rsb`=0x1234ABCD, `wready` delayed 2 cycles after `awready` → `wstrb`=4'b1100, `wdata`=0xABCDABCD, `awvalid` drops after its own handshake, `lsu_send_valid` at cycle 5.
- Misaligned word load: addr 0x80000001 → no `arvalid` ever, `lsu_fault`=1 at cycle 1. Non-memory request with `exu_result`=0x42 → `memory_read_wd`=0x42 at cycle 1.
- `rresp`=2'b10 on a load → `lsu_fault`=1. `lsu_send_ready` held low 4 cycles → outputs stable and `lsu_receive_ready`=0 until the handshake completes.
- `rst` asserted while in RD_DATA → next cycle state is IDLE, `rready`=0 and `lsu_send_valid`=0. The following request completes normally.
